// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants, state encoding and pass-amount helpers for shift_sched
package shift_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [4:0] pass1_sh(input logic [5:0] amt);
    return amt[5] ? 5'd31 : amt[4:0];
  endfunction

  // Pass 2 covers amt-31; amt=63 would need 32, but 62 already saturates every mode.
  function automatic logic [4:0] pass2_sh(input logic [5:0] amt);
    logic [5:0] rem;
    rem = amt - 6'd31;
    return rem[5] ? 5'd31 : rem[4:0];
  endfunction

endpackage

// File: rtl/shift_sched_shifter.sv
// rtl/shift_sched_shifter.sv - 32-bit combinational shifter, 5-bit amount, fill from in[31]
module shift_sched_shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [4:0]        sh,
  input  logic [1:0]        shift_con,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = in;
    case (shift_con)
      SH_SLL:  out = in << sh;
      SH_SRL:  out = in >> sh;
      SH_SRA:  out = $signed(in) >>> sh;
      default: out = in;
    endcase
  end

endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - two-requester scheduler sharing one shifter over one or two passes
module shift_sched
  import shift_pkg::*;
#(
  parameter int AMT_W = 6,
  parameter bit RR_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_data,
  input  logic [2*AMT_W-1:0]    req_amt,
  input  logic [3:0]            req_con,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_id,
  output logic                  busy
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   data_q, work_q;
  logic [AMT_W-1:0]    amt_q;
  logic [1:0]          con_q;
  logic                id_q;
  logic                rr_last;

  logic                gnt_any, gnt_id;
  logic [DATA_W-1:0]   sh_in, sh_out;
  logic [4:0]          sh_amt;

  // rr_last names the requester served most recently; the other one wins a tie.
  always_comb begin
    gnt_any = |req_valid;
    if (&req_valid) gnt_id = RR_EN ? ~rr_last : 1'b0;
    else            gnt_id = req_valid[1];
  end

  assign req_ready = (state == ST_IDLE && gnt_any) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // Pass 2 reuses the pass-1 result, whose bit 31 still carries the original sign.
  always_comb begin
    sh_in  = data_q;
    sh_amt = pass1_sh(amt_q);
    if (state == ST_PASS2) begin
      sh_in  = work_q;
      sh_amt = pass2_sh(amt_q);
    end
  end

  shift_sched_shifter u_shifter (
    .in        (sh_in),
    .sh        (sh_amt),
    .shift_con (con_q),
    .out       (sh_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_any) state_nxt = ST_PASS1;
      ST_PASS1: state_nxt = (amt_q[5] && con_q != SH_PASS) ? ST_PASS2 : ST_DONE;
      ST_PASS2: state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      data_q  <= '0;
      work_q  <= '0;
      amt_q   <= '0;
      con_q   <= SH_SLL;
      id_q    <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && gnt_any) begin
        data_q  <= gnt_id ? req_data[63:32] : req_data[31:0];
        amt_q   <= gnt_id ? req_amt[11:6]   : req_amt[5:0];
        con_q   <= gnt_id ? req_con[3:2]    : req_con[1:0];
        id_q    <= gnt_id;
        rr_last <= gnt_id;
      end
      if (state == ST_PASS1 || state == ST_PASS2) work_q <= sh_out;
    end
  end

  assign out_valid = (state == ST_DONE);
  assign out_data  = work_q;
  assign out_id    = id_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - directed vector bench for shift_sched
module tb_shift_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [11:0] req_amt;
  logic [3:0]  req_con;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_sched #(.AMT_W(6), .RR_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_con   (req_con),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [5:0]  amt;
    logic [1:0]  con;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [31:0] d, input logic [5:0] a, input logic [1:0] c);
    req_valid = id ? 2'b10 : 2'b01;
    if (id) begin
      req_data[63:32] = d; req_amt[11:6] = a; req_con[3:2] = c;
    end else begin
      req_data[31:0]  = d; req_amt[5:0]  = a; req_con[1:0]  = c;
    end
  endtask

  task automatic scramble();
    req_valid = 2'b00;
    req_data  = {$urandom, $urandom};
    req_amt   = 12'($urandom);
    req_con   = 4'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b00; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one request, wait for its result, check data/id/latency and the handshake.
  task automatic run_vec(input int k);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_req(vecs[k].id, vecs[k].data, vecs[k].amt, vecs[k].con);
    #1;
    check($sformatf("v%0d ready", k), 32'(req_ready), vecs[k].id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    scramble();
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("v%0d latency", k), 32'(n), 32'(vecs[k].lat));
    check($sformatf("v%0d data", k), out_data, vecs[k].exp);
    check($sformatf("v%0d id", k), 32'(out_id), 32'(vecs[k].id));
    @(posedge clk); #1;
    check($sformatf("v%0d idle after", k), {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ids_seen [4];
    logic [31:0] dat_seen [4];
    int          got;
    int          n;
    logic        saw_valid;

    vecs[0]  = '{1'b0, 32'h0000_0001,  6'd4, 2'b00, 32'h0000_0010, 2};
    vecs[1]  = '{1'b1, 32'h8000_0000, 6'd40, 2'b10, 32'hFFFF_FFFF, 3};
    vecs[2]  = '{1'b0, 32'hF000_0000, 6'd28, 2'b01, 32'h0000_000F, 2};
    vecs[3]  = '{1'b1, 32'h0000_0001, 6'd63, 2'b00, 32'h0000_0000, 3};
    vecs[4]  = '{1'b0, 32'hDEAD_BEEF, 6'd50, 2'b11, 32'hDEAD_BEEF, 2};
    vecs[5]  = '{1'b1, 32'h1234_5678,  6'd0, 2'b00, 32'h1234_5678, 2};
    vecs[6]  = '{1'b0, 32'h8000_0000, 6'd31, 2'b01, 32'h0000_0001, 2};
    vecs[7]  = '{1'b1, 32'h8000_0000, 6'd32, 2'b01, 32'h0000_0000, 3};
    vecs[8]  = '{1'b0, 32'h7FFF_FFFF, 6'd63, 2'b10, 32'h0000_0000, 3};
    vecs[9]  = '{1'b1, 32'h9000_0000, 6'd33, 2'b10, 32'hFFFF_FFFF, 3};
    vecs[10] = '{1'b0, 32'h4000_0000, 6'd30, 2'b10, 32'h0000_0001, 2};
    vecs[11] = '{1'b1, 32'h0000_0003, 6'd31, 2'b00, 32'h8000_0000, 2};
    vecs[12] = '{1'b0, 32'h8000_0001, 6'd32, 2'b10, 32'hFFFF_FFFF, 3};
    vecs[13] = '{1'b1, 32'h0000_0003, 6'd32, 2'b00, 32'h0000_0000, 3};

    rst = 1'b1; req_valid = 2'b00; req_data = '0; req_amt = '0; req_con = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_id", 32'(out_id), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) run_vec(k);

    // Both requesters valid continuously: grants alternate starting with req 0.
    do_reset();
    req_data  = {32'h0000_0001, 32'hF000_0000};
    req_amt   = {6'd63, 6'd28};
    req_con   = {2'b00, 2'b01};
    req_valid = 2'b11;
    out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) begin
        ids_seen[got] = 32'(out_id);
        dat_seen[got] = out_data;
        got++;
      end
    end
    req_valid = 2'b00;
    check("rr result count", 32'(got), 32'd4);
    for (int i = 0; i < got; i++) begin
      check($sformatf("rr id %0d", i), ids_seen[i], 32'(i % 2));
      check($sformatf("rr data %0d", i), dat_seen[i], (i % 2 == 0) ? 32'h0000_000F : 32'h0000_0000);
    end
    @(posedge clk); #1;

    // Backpressure in DONE with both requesters pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_req(1'b0, 32'h0000_0001, 6'd4, 2'b00);
    @(posedge clk); #1;
    req_valid = 2'b11;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp data %0d", i), out_data, 32'h0000_0010);
      check($sformatf("bp id/ready/busy/valid %0d", i), {27'd0, out_id, req_ready, busy, out_valid}, 32'b00011);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("bp released", {30'd0, out_valid, busy}, 32'd0);
    @(posedge clk); #1;
    check("bp single transfer", 32'(out_valid), 32'd0);

    // Reset during PASS2 of a req 0 request: result dropped, rr_last back to 1.
    drive_req(1'b0, 32'h0000_00FF, 6'd40, 2'b00);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid reset out_valid/busy", {30'd0, out_valid, busy}, 32'd0);
    check("mid reset out_data", out_data, 32'd0);
    req_valid = 2'b11;
    #1;
    check("post reset grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("dropped request silent", 32'(saw_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
